// File: rtl/mem_arbiter.sv
// Two-port memory arbiter (instruction fetch + data) onto one memory port with one transaction outstanding.
// Data wins by default; fetch is forced through after STARVE_LIMIT consecutive losses.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic        if_flush_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_be_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        drop_q, drop_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        both_req_s;
    logic        fetch_wins_s;
    logic        fetch_flush_s;
    logic        gnt_ev_s;
    logic        rsp_ev_s;
    logic        fetch_ok_s;
    logic        if_rvalid_s;
    logic        d_rvalid_s;

    // Next-state: arbitration, field latching, starvation counter and flush-drop tracking
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        starve_cnt_d  = starve_cnt_q;
        drop_d        = drop_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_be_d      = mem_be_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        both_req_s    = if_req_i & d_req_i;
        fetch_wins_s  = if_req_i & (~d_req_i | (starve_cnt_q >= STARVE_MAX));
        fetch_flush_s = (owner_q == OWN_FETCH) & if_flush_i;
        case (state_q)
            ST_IDLE: begin
                if (if_req_i | d_req_i) begin
                    state_d   = ST_REQ;
                    mem_req_d = 1'b1;
                    if (fetch_wins_s) begin
                        owner_d      = OWN_FETCH;
                        starve_cnt_d = 4'd0;
                        mem_we_d     = 1'b0;
                        mem_be_d     = 4'hF;
                        mem_addr_d   = if_addr_i;
                        mem_wdata_d  = 32'h0;
                    end else begin
                        owner_d     = OWN_DATA;
                        mem_we_d    = d_we_i;
                        mem_be_d    = d_be_i;
                        mem_addr_d  = d_addr_i;
                        mem_wdata_d = d_wdata_i;
                        // Saturating so a corrupted count can never run past the limit
                        if (both_req_s && (starve_cnt_q < STARVE_MAX)) begin
                            starve_cnt_d = starve_cnt_q + 4'd1;
                        end else begin
                            starve_cnt_d = starve_cnt_q;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                drop_d = drop_q | fetch_flush_s;
                if (mem_gnt_i) begin
                    state_d     = ST_RESP;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_be_d    = 4'h0;
                    mem_addr_d  = 32'h0;
                    mem_wdata_d = 32'h0;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_RESP: begin
                if (mem_rvalid_i) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b0;
                end else begin
                    state_d = ST_RESP;
                    drop_d  = drop_q | fetch_flush_s;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                drop_d    = 1'b0;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Requester handshakes are forwarded in the same cycle as the memory event
    always_comb begin
        gnt_ev_s    = (state_q == ST_REQ) & mem_gnt_i;
        rsp_ev_s    = (state_q == ST_RESP) & mem_rvalid_i;
        fetch_ok_s  = (owner_q == OWN_FETCH) & ~drop_q & ~if_flush_i;
        if_rvalid_s = rsp_ev_s & fetch_ok_s;
        d_rvalid_s  = rsp_ev_s & (owner_q == OWN_DATA);
        if_gnt_o    = gnt_ev_s & fetch_ok_s;
        d_gnt_o     = gnt_ev_s & (owner_q == OWN_DATA);
        if_rvalid_o = if_rvalid_s;
        d_rvalid_o  = d_rvalid_s;
        if_rdata_o  = if_rvalid_s ? mem_rdata_i : 32'h0;
        d_rdata_o   = d_rvalid_s ? mem_rdata_i : 32'h0;
    end

    // State and latched memory-side request registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_FETCH;
            starve_cnt_q <= 4'd0;
            drop_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'h0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            drop_q       <= drop_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_be_o    = mem_be_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, starvation order, mid-transaction reset,
// and randomized traffic checked against a transaction-level reference model.
module tb_mem_arbiter;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        if_req_i = 1'b0, if_flush_i = 1'b0;
    logic [31:0] if_addr_i = 32'h0;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i = 1'b0, d_we_i = 1'b0;
    logic [3:0]  d_be_i = 4'h0;
    logic [31:0] d_addr_i = 32'h0, d_wdata_i = 32'h0;
    logic        d_gnt_o, d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
        .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic any_out();
        return |{mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, if_gnt_o, if_rvalid_o,
                 if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o};
    endfunction

    typedef struct packed {
        logic        if_req;
        logic [31:0] if_addr;
        logic        flush;
        logic        d_req;
        logic        d_we;
        logic [3:0]  d_be;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
    } in_t;

    typedef struct packed {
        logic        req;
        logic        we;
        logic        own_d;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ig;
        logic        irv;
        logic [31:0] ird;
        logic        dg;
        logic        drv;
        logic [31:0] drd;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    function automatic in_t fin(logic r, logic [31:0] a, logic fl, logic g, logic rv, logic [31:0] rd);
        in_t v;
        v = '0;
        v.if_req = r; v.if_addr = a; v.flush = fl; v.gnt = g; v.rv = rv; v.rdata = rd;
        return v;
    endfunction

    function automatic in_t gin(logic r, logic [31:0] a, logic fl, logic dr, logic we, logic [3:0] be,
                                logic [31:0] da, logic [31:0] wd, logic g, logic rv, logic [31:0] rd);
        in_t v;
        v = fin(r, a, fl, g, rv, rd);
        v.d_req = dr; v.d_we = we; v.d_be = be; v.d_addr = da; v.d_wdata = wd;
        return v;
    endfunction

    function automatic exp_t ex_none();
        exp_t e;
        e = '0;
        return e;
    endfunction

    function automatic exp_t ex_req(logic we, logic own_d, logic [3:0] be, logic [31:0] a, logic [31:0] wd,
                                    logic ig, logic dg);
        exp_t e;
        e = '0;
        e.req = 1'b1; e.we = we; e.own_d = own_d; e.be = be; e.addr = a; e.wdata = wd;
        e.ig = ig; e.dg = dg;
        return e;
    endfunction

    function automatic exp_t ex_rsp(logic irv, logic drv, logic [31:0] rd);
        exp_t e;
        e = '0;
        e.irv = irv; e.drv = drv;
        e.ird = irv ? rd : 32'h0;
        e.drd = drv ? rd : 32'h0;
        return e;
    endfunction

    task automatic drive(input in_t v);
        if_req_i = v.if_req; if_addr_i = v.if_addr; if_flush_i = v.flush;
        d_req_i = v.d_req; d_we_i = v.d_we; d_be_i = v.d_be; d_addr_i = v.d_addr; d_wdata_i = v.d_wdata;
        mem_gnt_i = v.gnt; mem_rvalid_i = v.rv; mem_rdata_i = v.rdata;
    endtask

    task automatic check_exp(input string tag, input exp_t e);
        chk1({tag, ".mem_req"}, mem_req_o, e.req);
        if (e.req) begin
            chk32({tag, ".mem_addr"}, mem_addr_o, e.addr);
            chk1({tag, ".mem_we"}, mem_we_o, e.we);
            if (e.own_d) begin
                chk32({tag, ".mem_be"}, {28'h0, mem_be_o}, {28'h0, e.be});
                chk32({tag, ".mem_wdata"}, mem_wdata_o, e.wdata);
            end
        end
        chk1({tag, ".if_gnt"}, if_gnt_o, e.ig);
        chk1({tag, ".if_rvalid"}, if_rvalid_o, e.irv);
        chk32({tag, ".if_rdata"}, if_rdata_o, e.ird);
        chk1({tag, ".d_gnt"}, d_gnt_o, e.dg);
        chk1({tag, ".d_rvalid"}, d_rvalid_o, e.drv);
        chk32({tag, ".d_rdata"}, d_rdata_o, e.drd);
    endtask

    vec_t vt [29];

    initial begin
        // lone fetch, 2-cycle grant latency
        vt[0]  = '{fin(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0), ex_none()};
        vt[1]  = '{fin(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0), ex_req(1'b0, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0, 1'b0)};
        vt[2]  = '{fin(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0), ex_req(1'b0, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0, 1'b0)};
        vt[3]  = '{fin(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 32'h0), ex_req(1'b0, 1'b0, 4'hF, 32'h100, 32'h0, 1'b1, 1'b0)};
        vt[4]  = '{fin(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF), ex_rsp(1'b1, 1'b0, 32'hDEADBEEF)};
        vt[5]  = '{fin(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0), ex_none()};
        // simultaneous requests: data write first, then fetch
        vt[6]  = '{gin(1'b1, 32'h300, 1'b0, 1'b1, 1'b1, 4'hF, 32'h200, 32'h12345678, 1'b0, 1'b0, 32'h0), ex_none()};
        vt[7]  = '{gin(1'b1, 32'h300, 1'b0, 1'b1, 1'b1, 4'hF, 32'h200, 32'h12345678, 1'b1, 1'b0, 32'h0),
                   ex_req(1'b1, 1'b1, 4'hF, 32'h200, 32'h12345678, 1'b0, 1'b1)};
        vt[8]  = '{fin(1'b1, 32'h300, 1'b0, 1'b0, 1'b1, 32'h55), ex_rsp(1'b0, 1'b1, 32'h55)};
        vt[9]  = '{fin(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'h0), ex_none()};
        vt[10] = '{fin(1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 32'h0), ex_req(1'b0, 1'b0, 4'hF, 32'h300, 32'h0, 1'b1, 1'b0)};
        vt[11] = '{fin(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0), ex_none()};
        vt[12] = '{fin(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h11112222), ex_rsp(1'b1, 1'b0, 32'h11112222)};
        // flush during fetch response phase drops the data
        vt[13] = '{fin(1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 32'h0), ex_none()};
        vt[14] = '{fin(1'b1, 32'h400, 1'b0, 1'b1, 1'b0, 32'h0), ex_req(1'b0, 1'b0, 4'hF, 32'h400, 32'h0, 1'b1, 1'b0)};
        vt[15] = '{fin(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0), ex_none()};
        vt[16] = '{fin(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D), ex_none()};
        vt[17] = '{fin(1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 32'h0), ex_none()};
        vt[18] = '{fin(1'b1, 32'h500, 1'b0, 1'b1, 1'b0, 32'h0), ex_req(1'b0, 1'b0, 4'hF, 32'h500, 32'h0, 1'b1, 1'b0)};
        vt[19] = '{fin(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hABCD0123), ex_rsp(1'b1, 1'b0, 32'hABCD0123)};
        // stray memory events in IDLE/REQ, flush while data owns, gnt+rvalid together
        vt[20] = '{fin(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0), ex_none()};
        vt[21] = '{gin(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 4'h3, 32'h600, 32'h0, 1'b0, 1'b0, 32'h0), ex_none()};
        vt[22] = '{gin(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 4'h3, 32'h600, 32'h0, 1'b0, 1'b1, 32'h99),
                   ex_req(1'b0, 1'b1, 4'h3, 32'h600, 32'h0, 1'b0, 1'b0)};
        vt[23] = '{gin(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 4'h3, 32'h600, 32'h0, 1'b1, 1'b1, 32'h88),
                   ex_req(1'b0, 1'b1, 4'h3, 32'h600, 32'h0, 1'b0, 1'b1)};
        vt[24] = '{gin(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h77), ex_rsp(1'b0, 1'b1, 32'h77)};
        // flush coincident with the fetch grant
        vt[25] = '{fin(1'b1, 32'h700, 1'b0, 1'b0, 1'b0, 32'h0), ex_none()};
        vt[26] = '{fin(1'b1, 32'h700, 1'b1, 1'b1, 1'b0, 32'h0), ex_req(1'b0, 1'b0, 4'hF, 32'h700, 32'h0, 1'b0, 1'b0)};
        vt[27] = '{fin(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1234), ex_none()};
        vt[28] = '{fin(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0), ex_none()};

        // Reset holds every output low even with live inputs
        if_req_i = 1'b1; d_req_i = 1'b1; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF;
        repeat (3) @(negedge clk);
        #1;
        chk1("reset.outs_zero", any_out(), 1'b0);
        @(negedge clk);
        rst_ni = 1'b1;

        for (int i = 0; i < 29; i++) begin
            drive(vt[i].i);
            #1;
            check_exp($sformatf("v%0d", i), vt[i].e);
            @(negedge clk);
        end

        // Both ports requesting continuously, memory answering as fast as allowed
        begin
            string got;
            string want;
            int    n;
            int    losses;
            bit    pend;
            got = ""; want = ""; n = 0; losses = 0; pend = 1'b0;
            drive(fin(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
            if_addr_i = 32'h1000; d_addr_i = 32'h2000; d_be_i = 4'hF;
            for (int c = 0; c < 200; c++) begin
                if_req_i = (n < 10); d_req_i = (n < 10);
                mem_gnt_i = mem_req_o; mem_rvalid_i = pend; mem_rdata_i = 32'(c);
                #1;
                if (if_gnt_o) got = {got, "F"};
                if (d_gnt_o) got = {got, "D"};
                if (if_gnt_o || d_gnt_o) n++;
                pend = if_gnt_o | d_gnt_o;
                @(negedge clk);
                if (n >= 10 && !pend) break;
            end
            for (int k = 0; k < 10; k++) begin
                if (losses == LIMIT) begin
                    want = {want, "F"};
                    losses = 0;
                end else begin
                    want = {want, "D"};
                    losses++;
                end
            end
            total++;
            if (got != want) begin
                bad++;
                $display("FAIL starve.order: got %s want %s", got, want);
            end
            drive(fin(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
            @(negedge clk);
        end

        // Reset pulse while a data read waits for its grant
        drive(gin(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h800, 32'h0, 1'b0, 1'b0, 32'h0));
        @(negedge clk);
        #1;
        chk1("rst_mid.pre_req", mem_req_o, 1'b1);
        #1;
        rst_ni = 1'b0;
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD0001;
        #1;
        chk1("rst_mid.outs_zero", any_out(), 1'b0);
        @(negedge clk);
        rst_ni = 1'b1;
        drive(fin(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD0002));
        for (int c = 0; c < 2; c++) begin
            #1;
            chk1($sformatf("rst_mid.stale%0d", c), any_out(), 1'b0);
            @(negedge clk);
        end
        drive(fin(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
        @(negedge clk);

        // Randomized traffic against a transaction-level model
        begin
            int          losses;
            bit          wait_g, wait_r, cur_f, dropped, rel_f, rel_d;
            bit          e_ig, e_dg, e_irv, e_drv;
            logic [31:0] c_addr, c_wdata;
            logic        c_we;
            logic [3:0]  c_be;
            losses = 0; wait_g = 1'b0; wait_r = 1'b0; cur_f = 1'b0; dropped = 1'b0;
            rel_f = 1'b0; rel_d = 1'b0;
            c_addr = 32'h0; c_wdata = 32'h0; c_we = 1'b0; c_be = 4'h0;
            for (int cyc = 0; cyc < 1500; cyc++) begin
                if (rel_f) if_req_i = 1'b0;
                if (rel_d) d_req_i = 1'b0;
                if (!if_req_i && $urandom_range(2) == 0) begin
                    if_req_i = 1'b1; if_addr_i = $urandom;
                end
                if (!d_req_i && $urandom_range(2) == 0) begin
                    d_req_i = 1'b1; d_we_i = 1'($urandom_range(1)); d_be_i = 4'($urandom_range(15));
                    d_addr_i = $urandom; d_wdata_i = $urandom;
                end
                mem_gnt_i = 1'($urandom_range(1));
                mem_rvalid_i = 1'($urandom_range(1));
                mem_rdata_i = $urandom;
                if_flush_i = ($urandom_range(7) == 0);
                #1;
                e_ig  = wait_g && mem_gnt_i && cur_f && !dropped && !if_flush_i;
                e_dg  = wait_g && mem_gnt_i && !cur_f;
                e_irv = wait_r && mem_rvalid_i && cur_f && !dropped && !if_flush_i;
                e_drv = wait_r && mem_rvalid_i && !cur_f;
                chk1($sformatf("r%0d.mem_req", cyc), mem_req_o, wait_g);
                if (wait_g) begin
                    chk32($sformatf("r%0d.mem_addr", cyc), mem_addr_o, c_addr);
                    chk1($sformatf("r%0d.mem_we", cyc), mem_we_o, c_we);
                    if (!cur_f) begin
                        chk32($sformatf("r%0d.mem_be", cyc), {28'h0, mem_be_o}, {28'h0, c_be});
                        chk32($sformatf("r%0d.mem_wdata", cyc), mem_wdata_o, c_wdata);
                    end
                end
                chk1($sformatf("r%0d.if_gnt", cyc), if_gnt_o, e_ig);
                chk1($sformatf("r%0d.d_gnt", cyc), d_gnt_o, e_dg);
                chk1($sformatf("r%0d.if_rvalid", cyc), if_rvalid_o, e_irv);
                chk32($sformatf("r%0d.if_rdata", cyc), if_rdata_o, e_irv ? mem_rdata_i : 32'h0);
                chk1($sformatf("r%0d.d_rvalid", cyc), d_rvalid_o, e_drv);
                chk32($sformatf("r%0d.d_rdata", cyc), d_rdata_o, e_drv ? mem_rdata_i : 32'h0);
                if ((wait_g || wait_r) && cur_f && if_flush_i) dropped = 1'b1;
                if (wait_g) begin
                    if (mem_gnt_i) begin
                        wait_g = 1'b0; wait_r = 1'b1;
                    end
                end else if (wait_r) begin
                    if (mem_rvalid_i) begin
                        wait_r = 1'b0; dropped = 1'b0;
                    end
                end else if (if_req_i || d_req_i) begin
                    cur_f = if_req_i && (!d_req_i || losses == LIMIT);
                    if (cur_f) losses = 0;
                    else if (if_req_i) losses++;
                    c_addr = cur_f ? if_addr_i : d_addr_i;
                    c_we = cur_f ? 1'b0 : d_we_i;
                    c_be = d_be_i;
                    c_wdata = d_wdata_i;
                    wait_g = 1'b1;
                end
                rel_f = e_ig || if_flush_i;
                rel_d = e_dg;
                @(negedge clk);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive fetch losses while both ports request; legal range 1-15.
REQ-002 Port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-004 Fetch ports, all inputs except where noted:
- if_req_i, 1: fetch request.
- if_addr_i, 32: fetch address.
- if_flush_i, 1: discard the in-flight fetch.
- if_gnt_o, output, 1: fetch accepted by memory.
- if_rvalid_o, output, 1: fetch data valid.
- if_rdata_o, output, 32: fetch data.
REQ-005 Data ports, all inputs except where noted:
- d_req_i, 1: data request.
- d_we_i, 1: write when 1, read when 0.
- d_be_i, 4: byte enables.
- d_addr_i, 32: data address.
- d_wdata_i, 32: write data.
- d_gnt_o, output, 1: data request accepted.
- d_rvalid_o, output, 1: read data valid or write acknowledged.
- d_rdata_o, output, 32: read data.
REQ-006 Memory ports, all outputs except where noted:
- mem_req_o, 1: request.
- mem_we_o, 1: write.
- mem_be_o, 4: byte enables.
- mem_addr_o, 32: address.
- mem_wdata_o, 32: write data.
- mem_gnt_i, input, 1: memory accepted the request.
- mem_rvalid_i, input, 1: response; asserted for both reads and writes.
- mem_rdata_i, input, 32: response data.

Function
REQ-007 The block SHALL allow at most one memory transaction outstanding, using FSM states IDLE, REQ and RESP.
REQ-008 In IDLE with any request, the block SHALL arbitrate, latch the winner's fields into registers, record the owner and enter REQ on the next edge.
- mem_req_o SHALL rise exactly 1 cycle after the arbitration cycle.
REQ-009 Arbitration priority:
- Data wins by default.
- Fetch wins when both ports request and starve_cnt equals STARVE_LIMIT.
- A lone requester always wins.
REQ-010 starve_cnt (4 bits) SHALL:
- increment when both ports request and data wins;
- clear when fetch wins;
- hold otherwise;
- never exceed STARVE_LIMIT.
REQ-011 In REQ, mem_req_o and the latched mem_* fields SHALL be held stable until mem_gnt_i; the request SHALL never be retracted.
REQ-012 In the mem_gnt_i cycle, the owner's gnt_o SHALL be asserted combinationally for exactly that cycle, and the FSM SHALL enter RESP.
- The non-owner's gnt_o SHALL stay 0.
REQ-013 Requesters SHALL hold req and fields stable until their gnt_o; the block does not re-sample them after arbitration.
REQ-014 In RESP, mem_rvalid_i SHALL be forwarded combinationally to the owner's rvalid_o together with mem_rdata_i, and the FSM SHALL return to IDLE.
- Minimum throughput: one transaction per 3 cycles.
REQ-015 When there is no response for a port, its rdata_o SHALL be 0.
- A write acknowledgement drives d_rvalid_o=1 with d_rdata_o=mem_rdata_i, which is don't-care.
REQ-016 if_flush_i asserted while fetch owns a transaction in REQ or RESP SHALL set the drop flag.
- Drop suppresses the remaining if_gnt_o and if_rvalid_o of that transaction.
- The memory handshake still completes.
REQ-017 if_flush_i coincident with the grant or response cycle SHALL suppress that same-cycle if_gnt_o or if_rvalid_o.
REQ-018 if_flush_i in IDLE, or while data owns the bus, SHALL have no effect.
REQ-019 The drop flag SHALL clear on the transition to IDLE.
REQ-020 Mem_gnt_i outside REQ and mem_rvalid_i outside RESP SHALL be ignored.
REQ-021 Mem_gnt_i and mem_rvalid_i in the same cycle while in REQ SHALL be treated as a grant only; the response is expected later.

Reset
REQ-022 While rst_ni=0, the block SHALL hold:
- state IDLE, starve_cnt 0, drop 0, owner fetch;
- all mem_* outputs 0;
- all gnt_o, rvalid_o and rdata_o outputs 0.
REQ-023 Reset asserted mid-transaction SHALL abandon the transaction; no late response SHALL be forwarded after rst_ni rises.
REQ-024 Arbitration SHALL be possible in the first cycle after rst_ni deasserts.

Verification
REQ-025 Lone fetch read, addr 0x100, mem_gnt_i 2 cycles after mem_req_o, rvalid 1 cycle later with rdata 0xDEADBEEF -> mem_req_o at cycle+1, if_gnt_o for 1 cycle, if_rvalid_o with if_rdata_o=0xDEADBEEF, d_* stay 0.
REQ-026 Simultaneous requests, data write addr 0x200, be=0xF, wdata 0x12345678 -> data wins, mem_we_o=1, mem_be_o=0xF, d_rvalid_o on ack, fetch served next.
REQ-027 Both ports requesting continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,F,D,D,D,D,F; starve_cnt never exceeds 4.
REQ-028 if_flush_i during fetch RESP, then rvalid with 0xCAFEF00D -> if_rvalid_o stays 0, FSM returns to IDLE, next fetch served normally.
REQ-029 rst_ni pulsed low during REQ -> all outputs 0 immediately, and a stale mem_rvalid_i after release produces no rvalid_o.
